// File: rtl/sram_burst_ctrl_pkg.sv
// Shared definitions for the SRAM burst controller: FSM encoding, default base
// address and access time, and the byte-to-word address mapping.
// Pure declarations; no logic or latency of its own.
package sram_burst_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_READ  = 2'b01,
        S_WRITE = 2'b10
    } state_t;

    localparam logic [31:0] SRAM_BASE_ADDR  = 32'd1024;
    localparam int          WAIT_CYCLES_DEF = 6;

    // Byte address to SRAM word address. Addresses below the base wrap
    // modulo 2^32 on purpose; the caller truncates to the SRAM width.
    function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr,
                                                 input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_beat_timer.sv
// Access timer: counts the cycles of one SRAM access and flags its final cycle.
// Latency: last is combinational, high in the cycle where cnt == WAIT_CYCLES.
// Backpressure: none; the counter runs while run=1 and clears on last or run=0.
// Ports: clk, rst_n (sync, active-low), run in; cnt, last out.
module sram_beat_timer #(
    parameter int WAIT_CYCLES = 6,
    parameter int CNT_W       = $clog2(WAIT_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    assign last = run && (cnt == CNT_W'(WAIT_CYCLES));

    always_ff @(posedge clk) begin
        if (!rst_n || !run || last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_burst_ctrl.sv
// SRAM controller: single-word writes and aligned BURST_LEN-word line reads.
// Latency: write done at T(W+2); read beat k valid at T((k+1)(W+1)+1), done with last beat.
// Backpressure: req_ready is high only in IDLE; requests seen while busy are dropped.
// Ports: clk, rst_n (sync, active-low); req_valid/req_ready/req_write/req_addr/req_wdata
// request; rd_valid/rd_data/rd_beat read return; done completion pulse; SRAM_* pins.
module sram_burst_ctrl
    import sram_burst_ctrl_pkg::*;
#(
    parameter int          DATA_W      = 32,
    parameter int          SRAM_ADDR_W = 17,
    parameter int          WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int          BURST_LEN   = 2,
    parameter logic [31:0] BASE_ADDR   = SRAM_BASE_ADDR,
    localparam int         BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1,
    localparam int         CNT_W       = $clog2(WAIT_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    input  logic                   req_write,
    input  logic [31:0]            req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   req_ready,
    output logic                   rd_valid,
    output logic [DATA_W-1:0]      rd_data,
    output logic [BEAT_W-1:0]      rd_beat,
    output logic                   done,
    inout  wire  [DATA_W-1:0]      SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    // Clears the in-line word offset so a read always starts at the line base.
    localparam logic [SRAM_ADDR_W-1:0] LINE_MASK = ~(SRAM_ADDR_W'(BURST_LEN - 1));

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [SRAM_ADDR_W-1:0] req_waddr;
    logic [CNT_W-1:0]       cnt;
    logic                   last;
    logic                   accept;

    assign req_waddr = SRAM_ADDR_W'(byte_to_word(req_addr, BASE_ADDR));
    assign req_ready = (state_q == S_IDLE);
    assign accept    = req_valid && req_ready;

    sram_beat_timer #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .CNT_W       (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (state_q != S_IDLE),
        .cnt   (cnt),
        .last  (last)
    );

    // The controller only drives the data bus while a write is in flight,
    // including the final hold cycle with WE_N already released.
    assign SRAM_DQ = (state_q == S_WRITE) ? wdata_q : {DATA_W{1'bz}};

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        SRAM_ADDR = addr_q;
        SRAM_WE_N = 1'b1;
        SRAM_CE_N = 1'b0;
        SRAM_OE_N = 1'b1;
        SRAM_UB_N = 1'b0;
        SRAM_LB_N = 1'b0;
        case (state_q)
            S_IDLE: begin
                SRAM_CE_N = 1'b1;
                SRAM_ADDR = req_waddr;
                if (accept) begin
                    state_d = req_write ? S_WRITE : S_READ;
                    beat_d  = '0;
                end
            end
            S_WRITE: begin
                SRAM_WE_N = (cnt == CNT_W'(WAIT_CYCLES));
                if (last) begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                SRAM_OE_N = 1'b0;
                SRAM_ADDR = addr_q + SRAM_ADDR_W'(beat_q);
                if (last) begin
                    if (beat_q == BEAT_W'(BURST_LEN - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            beat_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_beat  <= '0;
            done     <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            if (accept) begin
                addr_q  <= req_write ? req_waddr : (req_waddr & LINE_MASK);
                wdata_q <= req_wdata;
            end
            if (state_q == S_READ && last) begin
                rd_valid <= 1'b1;
                rd_data  <= SRAM_DQ;
                rd_beat  <= beat_q;
            end
            // Completion of the whole request: write hold cycle or last read beat.
            if (last && state_d == S_IDLE) begin
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Bench for sram_burst_ctrl: directed requests against an SRAM model, with an
// expected-event scoreboard for rd_valid/done and per-cycle pin checks.
// Two instances: default timing (W=6) and a single-cycle-wait variant (W=1).
module tb_sram_burst_ctrl;

    localparam int W = 6;
    localparam logic [31:0] PULL = 32'hA5A5_5A5A;

    typedef struct {
        int          cyc;
        logic        rdv;
        logic        dn;
        logic [0:0]  beat;
        logic [31:0] data;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    ev_t q0[$];
    ev_t q1[$];

    // ---------------- DUT 0 (W=6, BL=2) ----------------
    logic        rst_n;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, rd_valid, done;
    logic [31:0] rd_data;
    logic [0:0]  rd_beat;
    wire  [31:0] sram_dq;
    logic [16:0] sram_addr;
    logic        sram_ub_n, sram_lb_n, sram_we_n, sram_ce_n, sram_oe_n;

    logic [31:0] mem [0:131071];

    assign sram_dq = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 32'bz;
    assign sram_dq = sram_ce_n ? PULL : 32'bz;
    always @(posedge clk) if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq;

    sram_burst_ctrl #(.WAIT_CYCLES(W), .BURST_LEN(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_beat(rd_beat), .done(done),
        .SRAM_DQ(sram_dq), .SRAM_ADDR(sram_addr), .SRAM_UB_N(sram_ub_n),
        .SRAM_LB_N(sram_lb_n), .SRAM_WE_N(sram_we_n), .SRAM_CE_N(sram_ce_n),
        .SRAM_OE_N(sram_oe_n)
    );

    // ---------------- DUT 1 (W=1) ----------------
    logic        req_valid1, req_write1;
    logic [31:0] req_addr1, req_wdata1;
    logic        req_ready1, rd_valid1, done1;
    logic [31:0] rd_data1;
    logic [0:0]  rd_beat1;
    wire  [31:0] sram_dq1;
    logic [16:0] sram_addr1;
    logic        sram_ub_n1, sram_lb_n1, sram_we_n1, sram_ce_n1, sram_oe_n1;

    assign sram_dq1 = sram_ce_n1 ? PULL : 32'bz;

    sram_burst_ctrl #(.WAIT_CYCLES(1), .BURST_LEN(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_ready(req_ready1),
        .rd_valid(rd_valid1), .rd_data(rd_data1), .rd_beat(rd_beat1), .done(done1),
        .SRAM_DQ(sram_dq1), .SRAM_ADDR(sram_addr1), .SRAM_UB_N(sram_ub_n1),
        .SRAM_LB_N(sram_lb_n1), .SRAM_WE_N(sram_we_n1), .SRAM_CE_N(sram_ce_n1),
        .SRAM_OE_N(sram_oe_n1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ev_t mk_ev(input int c, input logic rdv, input logic dn,
                                  input logic [0:0] beat, input logic [31:0] data);
        ev_t e;
        e.cyc = c; e.rdv = rdv; e.dn = dn; e.beat = beat; e.data = data;
        return e;
    endfunction

    // Move to the falling edge inside cycle c (c must not be in the past).
    task automatic go_to(input int c);
        @(negedge clk);
        while (cyc < c) @(negedge clk);
    endtask

    // Present one request at the current falling edge; it is accepted on the
    // next rising edge, so the current cycle is T0. Expected completion events
    // are queued here when expect_ev is set.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic expect_ev, input logic [31:0] exp0,
                         input logic [31:0] exp1, output int t0);
        check("issue_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = data;
        t0 = cyc;
        if (expect_ev) begin
            if (wr) begin
                q0.push_back(mk_ev(t0 + W + 2, 1'b0, 1'b1, 1'b0, 32'd0));
            end else begin
                q0.push_back(mk_ev(t0 + (W + 1) + 1,     1'b1, 1'b0, 1'b0, exp0));
                q0.push_back(mk_ev(t0 + 2 * (W + 1) + 1, 1'b1, 1'b1, 1'b1, exp1));
            end
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Scoreboard monitors: every rd_valid/done strobe must match the next
    // queued event, including the cycle it appears in.
    always @(negedge clk) begin
        if (rd_valid || done) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out0: got rd_valid=%0d done=%0d, want none (cycle %0d)",
                         rd_valid, done, cyc);
            end else begin
                ev_t e;
                e = q0.pop_front();
                check("ev0_cycle", 32'(cyc), 32'(e.cyc));
                check("ev0_rd_valid", 32'(rd_valid), 32'(e.rdv));
                check("ev0_done", 32'(done), 32'(e.dn));
                if (e.rdv) begin
                    check("ev0_rd_beat", 32'(rd_beat), 32'(e.beat));
                    check("ev0_rd_data", rd_data, e.data);
                end
                if (e.dn) check("ev0_ready_at_done", 32'(req_ready), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (rd_valid1 || done1) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_out1: got rd_valid=%0d done=%0d, want none (cycle %0d)",
                         rd_valid1, done1, cyc);
            end else begin
                ev_t e;
                e = q1.pop_front();
                check("ev1_cycle", 32'(cyc), 32'(e.cyc));
                check("ev1_done", 32'(done1), 32'(e.dn));
                check("ev1_ready_at_done", 32'(req_ready1), 32'd1);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0, t1, n;
        mem[4] = 32'h1111_1111; mem[5] = 32'h2222_2222;
        mem[6] = 32'h6666_6666; mem[7] = 32'h7777_7777;
        mem[8] = 32'h0;
        rst_n = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h414; req_wdata = 32'h0;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = 32'h400; req_wdata1 = 32'h0;

        // Reset held with a request pending: reset values, bus floating.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_req_ready", 32'(req_ready), 32'd1);
            check("rst_rd_valid", 32'(rd_valid), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_rd_beat", 32'(rd_beat), 32'd0);
            check("rst_rd_data", rd_data, 32'd0);
            check("rst_we_n", 32'(sram_we_n), 32'd1);
            check("rst_ce_n", 32'(sram_ce_n), 32'd1);
            check("rst_oe_n", 32'(sram_oe_n), 32'd1);
            check("rst_ub_lb", {30'd0, sram_ub_n, sram_lb_n}, 32'd0);
            check("rst_dq_float", sram_dq, PULL);
        end
        rst_n = 1'b1; req_valid = 1'b0;
        go_to(cyc + 1);
        check("no_accept_in_reset", 32'(sram_ce_n), 32'd1);

        // Single write of 0xDEADBEEF to 0x40C -> word 3.
        issue(1'b1, 32'h40C, 32'hDEAD_BEEF, 1'b1, 32'd0, 32'd0, t0);
        for (int k = 1; k <= 8; k++) begin
            go_to(t0 + k);
            check($sformatf("wr_we_n_T%0d", k), 32'(sram_we_n), (k <= W) ? 32'd0 : 32'd1);
            check($sformatf("wr_dq_T%0d", k), sram_dq, (k <= W + 1) ? 32'hDEAD_BEEF : PULL);
            check($sformatf("wr_ready_T%0d", k), 32'(req_ready), (k == W + 2) ? 32'd1 : 32'd0);
            if (k <= W + 1) check($sformatf("wr_addr_T%0d", k), 32'(sram_addr), 32'd3);
        end
        check("wr_mem3", mem[3], 32'hDEAD_BEEF);

        // Burst read at 0x414 -> line words 4,5.
        issue(1'b0, 32'h414, 32'd0, 1'b1, 32'h1111_1111, 32'h2222_2222, t0);
        for (int k = 1; k <= 14; k++) begin
            go_to(t0 + k);
            check($sformatf("rd_addr_T%0d", k), 32'(sram_addr), (k <= W + 1) ? 32'd4 : 32'd5);
            check($sformatf("rd_oe_n_T%0d", k), 32'(sram_oe_n), 32'd0);
        end
        go_to(t0 + 15);

        // Back-to-back: read of line 6/7, write to word 6 accepted in its done cycle.
        issue(1'b0, 32'h41C, 32'd0, 1'b1, 32'h6666_6666, 32'h7777_7777, t0);
        go_to(t0 + 15);
        issue(1'b1, 32'h418, 32'hCAFE_F00D, 1'b1, 32'd0, 32'd0, t1);
        check("b2b_accept_t", 32'(t1), 32'(t0 + 15));
        go_to(t1 + 1);
        check("b2b_we_n_T1", 32'(sram_we_n), 32'd0);
        check("b2b_addr_T1", 32'(sram_addr), 32'd6);
        go_to(t1 + W + 2);
        check("b2b_mem6", mem[6], 32'hCAFE_F00D);
        issue(1'b0, 32'h418, 32'd0, 1'b1, 32'hCAFE_F00D, 32'h7777_7777, t0);
        go_to(t0 + 15);

        // Reset at T4 of a read: request dropped silently.
        issue(1'b0, 32'h414, 32'd0, 1'b0, 32'd0, 32'd0, t0);
        go_to(t0 + 4);
        rst_n = 1'b0;
        go_to(t0 + 5);
        check("midrst_oe_n", 32'(sram_oe_n), 32'd1);
        check("midrst_ce_n", 32'(sram_ce_n), 32'd1);
        check("midrst_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;
        go_to(t0 + 25);
        issue(1'b1, 32'h420, 32'h1234_5678, 1'b1, 32'd0, 32'd0, t0);
        go_to(t0 + W + 2);
        check("post_rst_mem8", mem[8], 32'h1234_5678);

        // Address below the base wraps: 0 -> 0x3FFFFF00 -> 17 bits 0x1FF00.
        req_addr = 32'h0;
        #1 check("idle_addr_wrap", 32'(sram_addr), 32'h1FF00);
        issue(1'b1, 32'h0, 32'hA0A0_A0A0, 1'b1, 32'd0, 32'd0, t0);
        go_to(t0 + 1);
        check("busy_addr_wrap", 32'(sram_addr), 32'h1FF00);
        go_to(t0 + W + 2);

        // WAIT_CYCLES=1 instance: WE_N low at T1, hold at T2, done at T3.
        req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 32'h400; req_wdata1 = 32'h5555_AAAA;
        t0 = cyc;
        q1.push_back(mk_ev(t0 + 3, 1'b0, 1'b1, 1'b0, 32'd0));
        @(posedge clk);
        #1 req_valid1 = 1'b0;
        go_to(t0 + 1);
        check("w1_we_n_T1", 32'(sram_we_n1), 32'd0);
        check("w1_dq_T1", sram_dq1, 32'h5555_AAAA);
        check("w1_addr_T1", 32'(sram_addr1), 32'd0);
        go_to(t0 + 2);
        check("w1_we_n_T2", 32'(sram_we_n1), 32'd1);
        check("w1_ce_n_T2", 32'(sram_ce_n1), 32'd0);
        go_to(t0 + 4);

        // Every queued completion must have been seen within a bounded time.
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("pending_events", 32'(q0.size() + q1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
